// File: rtl/rc4_key_dispatcher_pkg.sv
// Shared types and helpers for the RC4 key dispatcher: state encoding and
// the lowest-set-bit arbiter used for both hit and service selection.
package rc4_key_dispatcher_pkg;

  localparam int unsigned KEY_W_DEFAULT = 22;
  localparam int unsigned MAX_CORES     = 32;
  localparam int unsigned MAX_IDX_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_FOUND,
    ST_EXHAUSTED
  } disp_state_t;

  typedef struct packed {
    logic                 hit;
    logic [MAX_IDX_W-1:0] idx;
  } lowest_t;

  function automatic lowest_t lowest_set(input logic [MAX_CORES-1:0] vec);
    lowest_t res;
    res.hit = 1'b0;
    res.idx = '0;
    for (int unsigned i = 0; i < MAX_CORES; i++) begin
      if (vec[i] && !res.hit) begin
        res.hit = 1'b1;
        res.idx = MAX_IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rc4_key_dispatcher_if.sv
// Per-core key/restart and finish/valid bundle between the dispatcher
// (master) and the decrypt cores (slave).
interface rc4_key_dispatcher_if #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned KEY_W     = 22
);
  logic [NUM_CORES-1:0]       core_finish;
  logic [NUM_CORES-1:0]       core_valid;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic [NUM_CORES-1:0]       core_restart;

  modport master (
    input  core_finish,
    input  core_valid,
    output core_key,
    output core_restart
  );

  modport slave (
    output core_finish,
    output core_valid,
    input  core_key,
    input  core_restart
  );
endinterface

// File: rtl/rc4_key_dispatcher.sv
// Central key scheduler for the multi-core RC4 search: hands out unique keys,
// restarts finished cores and latches the first valid key.
module rc4_key_dispatcher
  import rc4_key_dispatcher_pkg::*;
#(
  parameter int unsigned     NUM_CORES     = 2,
  parameter int unsigned     KEY_W         = KEY_W_DEFAULT,
  parameter logic [KEY_W-1:0] KEY_MAX      = {KEY_W{1'b1}},
  parameter int unsigned     RESTART_BLANK = 2,
  localparam int unsigned    IDX_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  rc4_key_dispatcher_if.master    core_bus,
  output logic                    busy,
  output logic                    found,
  output logic                    exhausted,
  output logic [KEY_W-1:0]        found_key,
  output logic [IDX_W-1:0]        found_core,
  output logic [KEY_W:0]          keys_issued
);

  localparam int unsigned BLANK_W = (RESTART_BLANK > 0) ? $clog2(RESTART_BLANK + 1) : 1;
  localparam logic [KEY_W:0] KEY_MAX_X = {1'b0, KEY_MAX};
  localparam logic [KEY_W:0] N_LAUNCH =
    (KEY_MAX_X < (KEY_W+1)'(NUM_CORES - 1)) ? KEY_MAX_X + (KEY_W+1)'(1)
                                            : (KEY_W+1)'(NUM_CORES);

  disp_state_t r_state, w_state_next;

  logic [NUM_CORES-1:0] r_active, r_retired, r_restart;
  logic [KEY_W-1:0]     r_key   [NUM_CORES];
  logic [BLANK_W-1:0]   r_blank [NUM_CORES];
  logic [KEY_W:0]       r_next_key, r_keys_issued;
  logic                 r_found, r_exhausted;
  logic [KEY_W-1:0]     r_found_key;
  logic [IDX_W-1:0]     r_found_core;

  logic [NUM_CORES-1:0] w_elig, w_svc_onehot, w_retired_next;
  lowest_t              w_win, w_svc;
  logic [IDX_W-1:0]     w_win_idx, w_svc_idx;
  logic                 w_launch, w_in_run, w_can_issue;
  logic                 w_hit, w_issue, w_retire, w_exhaust;

  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_elig[i] = r_active[i] && (r_blank[i] == '0) && core_bus.core_finish[i];
    end
    w_win     = lowest_set(MAX_CORES'(w_elig & core_bus.core_valid));
    w_svc     = lowest_set(MAX_CORES'(w_elig));
    w_win_idx = IDX_W'(w_win.idx);
    w_svc_idx = IDX_W'(w_svc.idx);

    w_launch    = start && (r_state inside {ST_IDLE, ST_FOUND, ST_EXHAUSTED});
    w_in_run    = (r_state == ST_RUN);
    w_can_issue = (r_next_key <= KEY_MAX_X);

    // A hit suppresses servicing in the same cycle, so no restart races the win.
    w_hit    = w_in_run && w_win.hit;
    w_issue  = w_in_run && !w_win.hit && w_svc.hit && w_can_issue;
    w_retire = w_in_run && !w_win.hit && w_svc.hit && !w_can_issue;

    w_svc_onehot   = NUM_CORES'(1) << w_svc_idx;
    w_retired_next = r_retired | (w_retire ? w_svc_onehot : '0);
    w_exhaust      = w_in_run && !w_win.hit && (&w_retired_next);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: if (start) w_state_next = ST_LAUNCH;
      ST_LAUNCH:                       w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_win.hit)      w_state_next = ST_FOUND;
        else if (w_exhaust) w_state_next = ST_EXHAUSTED;
      end
      default:                         w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Launch work is registered on the accepting edge so pulses coincide with LAUNCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active      <= '0;
      r_retired     <= '0;
      r_restart     <= '0;
      r_next_key    <= '0;
      r_keys_issued <= '0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
      r_found_key   <= '0;
      r_found_core  <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        r_key[i]   <= '0;
        r_blank[i] <= '0;
      end
    end else begin
      r_restart <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (r_blank[i] != '0) r_blank[i] <= r_blank[i] - BLANK_W'(1);
      end

      if (w_launch) begin
        r_found       <= 1'b0;
        r_exhausted   <= 1'b0;
        r_found_key   <= '0;
        r_found_core  <= '0;
        r_next_key    <= N_LAUNCH;
        r_keys_issued <= N_LAUNCH;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
          if ((KEY_W+1)'(i) <= KEY_MAX_X) begin
            r_key[i]     <= KEY_W'(i);
            r_restart[i] <= 1'b1;
            r_active[i]  <= 1'b1;
            r_retired[i] <= 1'b0;
            r_blank[i]   <= BLANK_W'(RESTART_BLANK);
          end else begin
            r_active[i]  <= 1'b0;
            r_retired[i] <= 1'b1;
            r_blank[i]   <= '0;
          end
        end
      end

      if (w_hit) begin
        r_found      <= 1'b1;
        r_found_key  <= r_key[w_win_idx];
        r_found_core <= w_win_idx;
      end

      if (w_issue) begin
        r_key[w_svc_idx]     <= r_next_key[KEY_W-1:0];
        r_restart[w_svc_idx] <= 1'b1;
        r_blank[w_svc_idx]   <= BLANK_W'(RESTART_BLANK);
        r_next_key           <= r_next_key + (KEY_W+1)'(1);
        r_keys_issued        <= r_keys_issued + (KEY_W+1)'(1);
      end

      if (w_retire) begin
        r_active[w_svc_idx]  <= 1'b0;
        r_retired[w_svc_idx] <= 1'b1;
      end

      if (w_exhaust) r_exhausted <= 1'b1;
    end
  end

  always_comb begin
    core_bus.core_key = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_bus.core_key[i*KEY_W +: KEY_W] = r_key[i];
    end
  end

  assign core_bus.core_restart = r_restart;
  assign busy        = (r_state == ST_LAUNCH) || (r_state == ST_RUN);
  assign found       = r_found;
  assign exhausted   = r_exhausted;
  assign found_key   = r_found_key;
  assign found_core  = r_found_core;
  assign keys_issued = r_keys_issued;

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// Directed bench for rc4_key_dispatcher: two instances (KEY_MAX=5 and KEY_MAX=0)
// with a simple finish-after-5-cycles core model for the longer searches.
module tb_rc4_key_dispatcher;

  localparam int unsigned NC = 2;
  localparam int unsigned KW = 22;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;

  always #5 clk = ~clk;

  rc4_key_dispatcher_if #(.NUM_CORES(NC), .KEY_W(KW)) bus_a ();
  rc4_key_dispatcher_if #(.NUM_CORES(NC), .KEY_W(KW)) bus_b ();

  logic          busy_a, found_a, exh_a, busy_b, found_b, exh_b;
  logic [KW-1:0] fkey_a, fkey_b;
  logic [0:0]    fcore_a, fcore_b;
  logic [KW:0]   kiss_a, kiss_b;

  rc4_key_dispatcher #(
    .NUM_CORES(NC), .KEY_W(KW), .KEY_MAX(22'd5), .RESTART_BLANK(2)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .core_bus(bus_a),
    .busy(busy_a), .found(found_a), .exhausted(exh_a),
    .found_key(fkey_a), .found_core(fcore_a), .keys_issued(kiss_a)
  );

  rc4_key_dispatcher #(
    .NUM_CORES(NC), .KEY_W(KW), .KEY_MAX(22'd0), .RESTART_BLANK(2)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .core_bus(bus_b),
    .busy(busy_b), .found(found_b), .exhausted(exh_b),
    .found_key(fkey_b), .found_core(fcore_b), .keys_issued(kiss_b)
  );

  int n_checks, n_pass;
  bit auto_mode;
  int vkey;
  int cnt [NC];
  int mkey [NC];
  int issue_cnt [8];
  int rs_total, rs_at;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    bus_a.core_finish = '0;
    bus_a.core_valid  = '0;
    bus_b.core_finish = '0;
    bus_b.core_valid  = '0;
    for (int i = 0; i < NC; i++) begin
      cnt[i]  = 0;
      mkey[i] = 0;
    end
    for (int k = 0; k < 8; k++) issue_cnt[k] = 0;
    rs_total = 0;
  endtask

  // Core model: drop finish on restart, raise it 5 cycles later, valid only on vkey.
  task automatic model_update();
    for (int i = 0; i < NC; i++) begin
      if (bus_a.core_restart[i]) begin
        rs_total++;
        mkey[i] = int'(bus_a.core_key[i*KW +: KW]);
        if (mkey[i] < 8) issue_cnt[mkey[i]]++;
        bus_a.core_finish[i] = 1'b0;
        bus_a.core_valid[i]  = 1'b0;
        cnt[i] = 5;
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          bus_a.core_finish[i] = 1'b1;
          bus_a.core_valid[i]  = (mkey[i] == vkey);
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (auto_mode) model_update();
  endtask

  task automatic do_reset();
    auto_mode = 1'b0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic wait_done(input int budget, output bit done);
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      cyc();
      if (found_a || exh_a) done = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit done;
    n_checks = 0;
    n_pass   = 0;
    vkey     = -1;
    auto_mode = 1'b0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    model_reset();

    cyc();
    cyc();
    check("rst_restart", 64'(bus_a.core_restart), 64'd0);
    check("rst_key",     64'(bus_a.core_key), 64'd0);
    check("rst_busy",    64'(busy_a), 64'd0);
    check("rst_found",   64'(found_a), 64'd0);
    check("rst_exh",     64'(exh_a), 64'd0);
    check("rst_fkey",    64'(fkey_a), 64'd0);
    check("rst_fcore",   64'(fcore_a), 64'd0);
    check("rst_issued",  64'(kiss_a), 64'd0);
    rst = 1'b0;
    cyc();

    // Launch, simultaneous non-valid finishes, start ignored in RUN, both valid.
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    check("launch_restart", 64'(bus_a.core_restart), 64'b11);
    check("launch_keys",    64'(bus_a.core_key), {20'd0, 22'd1, 22'd0});
    check("launch_issued",  64'(kiss_a), 64'd2);
    check("launch_busy",    64'(busy_a), 64'd1);
    cyc();
    cyc();
    bus_a.core_finish = 2'b11;
    bus_a.core_valid  = 2'b00;
    cyc();
    check("sim_first_rs",  64'(bus_a.core_restart), 64'b01);
    check("sim_first_key", 64'(bus_a.core_key[21:0]), 64'd2);
    bus_a.core_finish[0] = 1'b0;
    cyc();
    check("sim_second_rs",  64'(bus_a.core_restart), 64'b10);
    check("sim_second_key", 64'(bus_a.core_key[43:22]), 64'd3);
    check("sim_key0_hold",  64'(bus_a.core_key[21:0]), 64'd2);
    bus_a.core_finish[1] = 1'b0;
    cyc();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    check("run_start_rs",     64'(bus_a.core_restart), 64'd0);
    check("run_start_issued", 64'(kiss_a), 64'd4);
    check("run_start_busy",   64'(busy_a), 64'd1);
    bus_a.core_finish = 2'b11;
    bus_a.core_valid  = 2'b11;
    cyc();
    check("both_valid_found", 64'(found_a), 64'd1);
    check("both_valid_core",  64'(fcore_a), 64'd0);
    check("both_valid_key",   64'(fkey_a), 64'd2);
    check("both_valid_busy",  64'(busy_a), 64'd0);
    bus_a.core_finish = 2'b00;
    bus_a.core_valid  = 2'b00;

    // Finish/valid held through the blank window must be ignored.
    do_reset();
    bus_a.core_finish = 2'b11;
    bus_a.core_valid  = 2'b11;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    check("blank_launch_rs", 64'(bus_a.core_restart), 64'b11);
    cyc();
    check("blank_l1_rs",    64'(bus_a.core_restart), 64'd0);
    check("blank_l1_found", 64'(found_a), 64'd0);
    bus_a.core_finish = 2'b00;
    bus_a.core_valid  = 2'b00;
    cyc();
    cyc();
    cyc();
    check("blank_l4_found",  64'(found_a), 64'd0);
    check("blank_l4_issued", 64'(kiss_a), 64'd2);
    bus_a.core_finish = 2'b01;
    cyc();
    check("blank_svc_rs",  64'(bus_a.core_restart), 64'b01);
    check("blank_svc_key", 64'(bus_a.core_key[21:0]), 64'd2);
    bus_a.core_valid = 2'b01;
    cyc();
    check("blank_hold_rs",    64'(bus_a.core_restart), 64'd0);
    check("blank_hold_found", 64'(found_a), 64'd0);
    bus_a.core_finish = 2'b00;
    bus_a.core_valid  = 2'b00;
    cyc();
    check("blank_end_issued", 64'(kiss_a), 64'd3);
    check("blank_end_found",  64'(found_a), 64'd0);

    // Model cores, valid only on key 3.
    do_reset();
    vkey = 3;
    auto_mode = 1'b1;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    wait_done(100, done);
    check("found_wait",   64'(done), 64'd1);
    check("found_flag",   64'(found_a), 64'd1);
    check("found_key",    64'(fkey_a), 64'd3);
    check("found_core",   64'(fcore_a), 64'd1);
    check("found_issued", 64'(kiss_a), 64'd5);
    check("found_exh",    64'(exh_a), 64'd0);
    check("found_busy",   64'(busy_a), 64'd0);
    rs_at = rs_total;
    check("found_restarts", 64'(rs_at), 64'd5);
    repeat (20) cyc();
    check("found_no_more_rs", 64'(rs_total - rs_at), 64'd0);

    // No valid key: every key once, then exhausted.
    do_reset();
    vkey = 99;
    auto_mode = 1'b1;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    wait_done(200, done);
    check("exh_wait",   64'(done), 64'd1);
    check("exh_flag",   64'(exh_a), 64'd1);
    check("exh_found",  64'(found_a), 64'd0);
    check("exh_issued", 64'(kiss_a), 64'd6);
    check("exh_busy",   64'(busy_a), 64'd0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("exh_key%0d_once", k), 64'(issue_cnt[k]), 64'd1);
    end
    check("exh_no_extra", 64'(issue_cnt[6] + issue_cnt[7]), 64'd0);

    // Reset mid-RUN, then a fresh search from key 0.
    do_reset();
    vkey = 99;
    auto_mode = 1'b1;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    repeat (8) cyc();
    check("mid_busy", 64'(busy_a), 64'd1);
    auto_mode = 1'b0;
    rst = 1'b1;
    model_reset();
    cyc();
    cyc();
    check("mid_rst_key",    64'(bus_a.core_key), 64'd0);
    check("mid_rst_busy",   64'(busy_a), 64'd0);
    check("mid_rst_issued", 64'(kiss_a), 64'd0);
    check("mid_rst_rs",     64'(bus_a.core_restart), 64'd0);
    rst = 1'b0;
    cyc();
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    check("mid_relaunch_rs",     64'(bus_a.core_restart), 64'b11);
    check("mid_relaunch_keys",   64'(bus_a.core_key), {20'd0, 22'd1, 22'd0});
    check("mid_relaunch_issued", 64'(kiss_a), 64'd2);

    // KEY_MAX = 0: only core 0 launched, exhausted after its finish.
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    check("km0_rs",     64'(bus_b.core_restart), 64'b01);
    check("km0_keys",   64'(bus_b.core_key), 64'd0);
    check("km0_issued", 64'(kiss_b), 64'd1);
    check("km0_busy",   64'(busy_b), 64'd1);
    cyc();
    check("km0_l1_rs", 64'(bus_b.core_restart), 64'd0);
    cyc();
    bus_b.core_finish = 2'b01;
    bus_b.core_valid  = 2'b00;
    cyc();
    check("km0_exh",   64'(exh_b), 64'd1);
    check("km0_found", 64'(found_b), 64'd0);
    check("km0_done_busy", 64'(busy_b), 64'd0);
    check("km0_done_rs",   64'(bus_b.core_restart), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rc4_key_dispatcher.md
# rc4_key_dispatcher

Central key scheduler and result collector for the multi-core RC4 brute-force search. It sits upstream of the per-core init/shuffle/decrypt pipelines and replaces the per-core key counters: it hands each core a unique secret key, restarts cores as they finish, and captures the first key whose decryption is flagged valid. It also stops the search on a hit or when the keyspace is exhausted.

## Interface
Parameters:
- NUM_CORES, 2, number of decrypt cores served.
- KEY_W, 22, width of the searched key; cores receive `{2'b0, key}` upstream of this block.
- KEY_MAX, 22'h3FFFFF, last key tried (inclusive).
- RESTART_BLANK, 2, cycles after a restart pulse during which that core's finish/valid are ignored.

Ports:
- clk, in, 1, system clock; single clock domain.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, begin a new search; honoured only in IDLE, FOUND, EXHAUSTED.
- core_finish, in, NUM_CORES, per-core level; high from decrypt completion until that core is restarted.
- core_valid, in, NUM_CORES, per-core key-valid flag; meaningful only while the matching core_finish is high.
- core_key, out, NUM_CORES*KEY_W, key for core i in slice [i*KEY_W +: KEY_W]; stable while the core runs.
- core_restart, out, NUM_CORES, one-cycle restart pulse per core.
- busy, out, 1, high in LAUNCH and RUN.
- found, out, 1, sticky hit flag.
- exhausted, out, 1, sticky keyspace-done flag with no hit.
- found_key, out, KEY_W, winning key; valid while found.
- found_core, out, $clog2(NUM_CORES), index of the winning core.
- keys_issued, out, KEY_W+1, count of keys handed out this search.

## Operation
- States: IDLE, LAUNCH, RUN, FOUND, EXHAUSTED.
- IDLE/FOUND/EXHAUSTED + start → LAUNCH. This clears found, exhausted, found_key, found_core and keys_issued, and sets next_key = 0.
- LAUNCH, one cycle:
  - For each core i with i ≤ KEY_MAX: core_key[i] = i, pulse core_restart[i], mark the core active, load its blank counter with RESTART_BLANK.
  - Cores with i > KEY_MAX are marked retired.
  - next_key = number launched; keys_issued likewise.
  - → RUN.
- RUN, each cycle:
  - A core is eligible when active, its blank counter = 0, and core_finish = 1.
  - If any eligible core has core_valid = 1: the lowest such index wins. Latch found_key = core_key[idx] and found_core = idx, set found, issue no restarts this cycle or later, → FOUND.
  - Else, if any core is eligible, service only the lowest eligible index this cycle; others wait, since finish is level-held.
    - If next_key ≤ KEY_MAX: core_key[idx] = next_key, pulse core_restart[idx], reload its blank counter, increment next_key and keys_issued.
    - Otherwise retire the core.
  - When every core is retired and there is no hit: set exhausted, → EXHAUSTED.
- FOUND/EXHAUSTED: outputs are held; core_restart stays 0.
- Arithmetic:
  - next_key is KEY_W+1 bits, so KEY_MAX = all-ones never wraps to 0.
  - Comparison against KEY_MAX is unsigned.
- start while in LAUNCH or RUN is ignored.
- rst at any time, including mid-search:
  - state = IDLE; all active/retired bits and blank counters = 0.
  - All outputs = 0 (core_key, core_restart, busy, found, exhausted, found_key, found_core, keys_issued).

## Timing
- start sampled high at cycle t → LAUNCH at t+1: core_restart pulses and new core_key values are visible at t+1. busy is high from t+1.
- An eligible finish+valid at cycle t → found = 1 and busy = 0 at t+1.
- An eligible finish without valid at t → restart pulse and new core_key at t+1.
- With two simultaneous eligible non-valid finishes, the restart pulses appear on consecutive cycles, lowest index first.
- The last retirement at t → exhausted at t+1.
- core_key[i] changes only in the same cycle its core_restart[i] pulses.

## Structure
- rc4_pkg holds:
  - KEY_W_DEFAULT;
  - typedef enum for the dispatcher state;
  - a function lowest_set(vector) → {hit, index} used for both valid-arbitration and service-arbitration.
- No sub-modules. Per-core blank counters and active/retired bits live in generate-free arrays within the block.

## Test plan
All scenarios use NUM_CORES=2, KEY_MAX=5, RESTART_BLANK=2 unless stated.
- Reset then start: restart = 2'b11, core_key = {1,0}, keys_issued = 2 one cycle after start; all outputs 0 while rst is high.
- Model cores that finish 5 cycles after restart with valid only on key 3 → found = 1, found_key = 3, found_core = 1, and no further restarts.
- No valid key → keys 0..5 each issued exactly once, then exhausted = 1, found = 0, keys_issued = 6.
- Both cores raise finish in the same cycle, neither valid → restart[0] first, restart[1] the next cycle, keys 2 and 3 respectively. With both valid → found_core = 0.
- finish held high during the blank window after a restart → ignored; no double issue and no false hit.
- rst asserted mid-RUN, then start → search restarts from key 0. Separately, with KEY_MAX = 0 → only core 0 is launched, and exhausted follows its non-valid finish.
